iter_shift_unit: RTL and testbench



---
 rtl/iter_shift_unit.sv | 122 ++++++++++++
 tb/tb_iter_shift_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// iter_shift_unit
//
// Multi-cycle shifter for the multicycle MIPS datapath. A start request loads
// the operand and shift distance, then the operand moves one bit position per
// clock until the distance is used up. The result stays on `result` from the
// done pulse until the next accepted start or reset.
//
// Handshake: start is sampled only in IDLE or DONE. An accepted start is a
// load. busy is high for each SHIFT cycle. done pulses for exactly one cycle
// after the last shift. busy and done are never high together, and a start
// seen while busy is dropped.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (priority over start)
//   start   request; sampled only when idle or done
//   op      00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   amount  shift distance 0..WIDTH-1
//   src     operand (signed for SRA)
//   busy    high while shifting
//   done    one-cycle completion pulse
//   result  shift register contents
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   amount,
  input  logic [WIDTH-1:0] src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_q;

  logic             load;
  logic [SHW-1:0]   eff_amount;
  logic [WIDTH-1:0] step_val;

  // Pass-through is treated as a zero-length shift so it finishes at once.
  assign eff_amount = (op == OP_PASS) ? '0 : amount;

  // The shifter is not waiting on anything in IDLE or DONE, so a start is
  // accepted in both. Accepting in DONE allows back-to-back operations.
  assign load = start && (state != S_SHIFT);

  // One-bit step using only the op latched at load time.
  always_comb begin
    step_val = sreg;
    case (op_q)
      OP_SLL:  step_val = {sreg[WIDTH-2:0], 1'b0};
      OP_SRL:  step_val = {1'b0, sreg[WIDTH-1:1]};
      OP_SRA:  step_val = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      default: step_val = sreg;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (load) state_next = (eff_amount != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        // A count of 1 means this edge performs the final shift.
        if (cnt == SHW'(1)) state_next = S_DONE;
      end
      S_DONE: begin
        if (load) state_next = (eff_amount != '0) ? S_SHIFT : S_DONE;
        else      state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Datapath: shift register, down-counter, latched op
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
      op_q <= OP_SLL;
    end else if (load) begin
      sreg <= src;
      cnt  <= eff_amount;
      op_q <= op;
    end else if (state == S_SHIFT) begin
      sreg <= step_val;
      cnt  <= cnt - SHW'(1);
    end
  end

  assign busy   = (state == S_SHIFT);
  assign done   = (state == S_DONE);
  assign result = sreg;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit.
// Each step drives a request, counts edges to done and busy cycles, and
// compares result, latency and busy count against hand-computed values.
// A monitor checks that busy and done are never high together.
module tb_iter_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  amount;
  logic [31:0] src;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .amount (amount),
    .src    (src),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy/done exclusion, checked every cycle away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      assert (!(busy && done)) else begin
        bad++;
        $error("FAIL busy_done_excl obs=%0b%0b exp=not_both", busy, done);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request and take the accepting edge E0; return 1 cycle later.
  task automatic begin_op(input logic [1:0] o, input logic [31:0] s, input logic [4:0] a);
    op     = o;
    src    = s;
    amount = a;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Wait for done. edges counts edges from E0 inclusive. If poke>0, start is
  // raised with amount=1 during the edge that ends cycle `poke`.
  task automatic wait_done(input int poke, output int edges, output int busy_cnt);
    edges    = 1;
    busy_cnt = 0;
    while (!done && edges < 64) begin
      if (busy) busy_cnt++;
      if (edges == poke) begin
        start  = 1'b1;
        amount = 5'd1;
        op     = 2'b00;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] s,
                        input logic [4:0] a, input logic [31:0] exp_res,
                        input int exp_edges, input int exp_busy);
    int e, b;
    begin_op(o, s, a);
    wait_done(0, e, b);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_edges"}, 32'(e), 32'(exp_edges));
    check({tag, "_busy"}, 32'(b), 32'(exp_busy));
  endtask

  initial begin
    int e, b;
    int seen_done;
    logic [31:0] rs, rexp;
    logic [4:0]  ra;
    logic [1:0]  ro;

    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    amount = '0;
    src    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // SLL 1 by 31: worst case
    run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, 31);
    @(posedge clk); #1;
    check("sll31_pulse_width", 32'(done), 32'd0);
    check("sll31_hold", result, 32'h8000_0000);

    run_op("sra4", 2'b10, 32'h8000_00F0, 5'd4, 32'hF800_000F, 5, 4);
    @(posedge clk); #1;
    run_op("srl4", 2'b01, 32'h8000_00F0, 5'd4, 32'h0800_000F, 5, 4);
    @(posedge clk); #1;

    run_op("sll0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678, 1, 0);
    @(posedge clk); #1;
    run_op("pass7", 2'b11, 32'h1234_5678, 5'd7, 32'h1234_5678, 1, 0);
    @(posedge clk); #1;

    // start while shifting is ignored
    begin_op(2'b01, 32'hFFFF_FFFF, 5'd8);
    wait_done(3, e, b);
    check("ign_result", result, 32'h00FF_FFFF);
    check("ign_edges", 32'(e), 32'd9);
    check("ign_busy", 32'(b), 32'd8);

    // back-to-back start accepted in the DONE cycle
    begin_op(2'b00, 32'h0000_0001, 5'd2);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(0, e, b);
    check("b2b_result", result, 32'h0000_0004);
    check("b2b_edges", 32'(e), 32'd3);

    // zero-length back-to-back: another done the very next cycle
    begin_op(2'b11, 32'hCAFE_F00D, 5'd3);
    check("b2b0_done", 32'(done), 32'd1);
    check("b2b0_result", result, 32'hCAFE_F00D);
    @(posedge clk); #1;
    check("b2b0_idle", 32'(done), 32'd0);

    // reset at the 5th shift edge
    begin_op(2'b10, 32'h8000_0000, 5'd16);
    repeat (4) begin @(posedge clk); #1; end
    check("rst_mid_busy_pre", 32'(busy), 32'd1);
    check("rst_mid_partial", result, 32'hF800_0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_result", result, 32'h0);
    seen_done = 0;
    repeat (20) begin
      if (done || busy) seen_done = 1;
      @(posedge clk); #1;
    end
    check("rst_mid_no_done", 32'(seen_done), 32'd0);
    run_op("after_rst", 2'b01, 32'h8000_0000, 5'd3, 32'h1000_0000, 4, 3);
    @(posedge clk); #1;

    // reset while in DONE
    begin_op(2'b11, 32'h5555_AAAA, 5'd0);
    check("rst_done_pre", 32'(done), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_done_done", 32'(done), 32'd0);
    check("rst_done_result", result, 32'h0);
    @(posedge clk); #1;

    // random operations against the operator equivalents
    for (int i = 0; i < 200; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 5'($urandom_range(0, 31));
      rs = $urandom;
      case (ro)
        2'b00:   rexp = rs << ra;
        2'b01:   rexp = rs >> ra;
        2'b10:   rexp = $signed(rs) >>> ra;
        default: rexp = rs;
      endcase
      run_op("rand", ro, rs, ra, rexp,
             (ro == 2'b11 || ra == 0) ? 1 : int'(ra) + 1,
             (ro == 2'b11) ? 0 : int'(ra));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
